// File: rtl/snd_mix_pkg.sv
// Shared constants for the four-channel gain mixer (snd_mix4 and snd_mix_scale).
package snd_mix_pkg;

  localparam int unsigned MIX_W     = 16;
  localparam int unsigned GAIN_W    = 8;
  localparam int unsigned GAIN_FRAC = 4;
  localparam int unsigned SUM_W     = 27;
  localparam int unsigned PROD_W    = MIX_W + GAIN_W + 1;

  localparam int MIX_MAX = 32767;
  localparam int MIX_MIN = -32768;

endpackage

// File: rtl/snd_mix_scale.sv
// Left-justifies one signed channel to 16 bits and multiplies by an unsigned 4.4 gain.
module snd_mix_scale
  import snd_mix_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic signed [W-1:0]      ch,
  input  logic        [GAIN_W-1:0] gain,
  output logic signed [PROD_W-1:0] prod
);

  logic signed [MIX_W-1:0] aligned;

  // Sign-extend first, then shift so the low bits are zero-filled.
  assign aligned = MIX_W'(ch) <<< (MIX_W - W);
  assign prod    = PROD_W'(aligned) * PROD_W'($signed({1'b0, gain}));

endmodule

// File: rtl/snd_mix4.sv
// Four-input signed mixer: gain, two-stage cen-gated pipeline, floor shift and saturation.
// Optional SND_MIX_CLIP_EN adds a registered clip flag.
module snd_mix4
  import snd_mix_pkg::*;
#(
  parameter int unsigned w0   = 16,
  parameter int unsigned w1   = 16,
  parameter int unsigned w2   = 16,
  parameter int unsigned w3   = 16,
  parameter int unsigned wout = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic signed [w0-1:0]   ch0,
  input  logic signed [w1-1:0]   ch1,
  input  logic signed [w2-1:0]   ch2,
  input  logic signed [w3-1:0]   ch3,
  input  logic [GAIN_W-1:0]      gain0,
  input  logic [GAIN_W-1:0]      gain1,
  input  logic [GAIN_W-1:0]      gain2,
  input  logic [GAIN_W-1:0]      gain3,
`ifdef SND_MIX_CLIP_EN
  output logic                   clip,
`endif
  output logic signed [wout-1:0] mixed
);

  localparam logic signed [SUM_W-1:0] SUM_HI = SUM_W'(MIX_MAX);
  localparam logic signed [SUM_W-1:0] SUM_LO = SUM_W'(MIX_MIN);

  logic signed [PROD_W-1:0] prod [4];
  logic signed [PROD_W-1:0] p_q  [4];
  logic signed [SUM_W-1:0]  sum, scaled;
  logic signed [MIX_W-1:0]  sat;
  logic                     over;
  logic signed [wout-1:0]   mixed_d, mixed_q;

  snd_mix_scale #(.W(w0)) u_scale0 (.ch(ch0), .gain(gain0), .prod(prod[0]));
  snd_mix_scale #(.W(w1)) u_scale1 (.ch(ch1), .gain(gain1), .prod(prod[1]));
  snd_mix_scale #(.W(w2)) u_scale2 (.ch(ch2), .gain(gain2), .prod(prod[2]));
  snd_mix_scale #(.W(w3)) u_scale3 (.ch(ch3), .gain(gain3), .prod(prod[3]));

  // Full-width sum so that opposing clipping inputs cancel before the clamp.
  always_comb begin
    sum    = SUM_W'(p_q[0]) + SUM_W'(p_q[1]) + SUM_W'(p_q[2]) + SUM_W'(p_q[3]);
    scaled = sum >>> GAIN_FRAC;
    over   = 1'b1;
    if (scaled > SUM_HI) begin
      sat = MIX_W'(MIX_MAX);
    end else if (scaled < SUM_LO) begin
      sat = MIX_W'(MIX_MIN);
    end else begin
      sat  = scaled[MIX_W-1:0];
      over = 1'b0;
    end
    mixed_d = sat[MIX_W-1 -: wout];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q     <= '{default: '0};
      mixed_q <= '0;
    end else if (cen) begin
      p_q     <= prod;
      mixed_q <= mixed_d;
    end
  end

  assign mixed = mixed_q;

`ifdef SND_MIX_CLIP_EN
  logic clip_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clip_q <= 1'b0;
    end else if (cen) begin
      clip_q <= over;
    end
  end

  assign clip = clip_q;
`else
  logic unused_over;
  assign unused_over = over;
`endif

endmodule

// File: tb/tb_snd_mix4.sv
// Self-checking bench for snd_mix4: directed table, reset/hold sequences, random vs. model.
module tb_snd_mix4;

  logic clk = 1'b0;
  logic rst, cen;
  logic signed [15:0] ch0, ch1, ch2;
  logic signed [7:0]  ch3;
  logic signed [15:0] ch3w;
  logic [7:0] gain0, gain1, gain2, gain3;
  logic signed [15:0] mixed;
  logic signed [11:0] mixed12;
  logic clip, clip12;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ch3w = {ch3, 8'h00};

  snd_mix4 #(.w0(16), .w1(16), .w2(16), .w3(8), .wout(16)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .gain0(gain0), .gain1(gain1), .gain2(gain2), .gain3(gain3),
`ifdef SND_MIX_CLIP_EN
    .clip(clip),
`endif
    .mixed(mixed)
  );

  snd_mix4 #(.w0(16), .w1(16), .w2(16), .w3(16), .wout(12)) dut12 (
    .clk(clk), .rst(rst), .cen(cen),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3w),
    .gain0(gain0), .gain1(gain1), .gain2(gain2), .gain3(gain3),
`ifdef SND_MIX_CLIP_EN
    .clip(clip12),
`endif
    .mixed(mixed12)
  );

`ifndef SND_MIX_CLIP_EN
  assign clip   = 1'b0;
  assign clip12 = 1'b0;
`endif

  typedef struct {
    int m;
    int m12;
    int c;
  } exp_t;

  typedef struct {
    int c0, c1, c2, c3;
    int g0, g1, g2, g3;
    int m, m12, c;
  } vec_t;

  exp_t hist[$];

  function automatic longint fdiv16(longint a);
    longint q;
    q = a / 16;
    if ((a % 16 != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: integer arithmetic straight from the mixing rules.
  function automatic exp_t model(int c0, int c1, int c2, int c3, int g0, int g1, int g2, int g3);
    exp_t e;
    longint s, t, sat;
    s = longint'(c0) * g0 + longint'(c1) * g1 + longint'(c2) * g2 + longint'(c3 * 256) * g3;
    t = fdiv16(s);
    sat = (t > 32767) ? 32767 : ((t < -32768) ? -32768 : t);
    e.m   = int'(sat);
    e.m12 = int'(fdiv16(sat));
    e.c   = (t > 32767 || t < -32768) ? 1 : 0;
    return e;
  endfunction

  function automatic exp_t cur_model();
    return model(int'(ch0), int'(ch1), int'(ch2), int'(ch3),
                 int'(gain0), int'(gain1), int'(gain2), int'(gain3));
  endfunction

  task automatic model_reset();
    exp_t z;
    z.m = 0; z.m12 = 0; z.c = 0;
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outputs(string name, exp_t e);
    chk({name, ".mixed"}, int'(mixed), e.m);
    chk({name, ".mixed12"}, int'(mixed12), e.m12);
`ifdef SND_MIX_CLIP_EN
    chk({name, ".clip"}, int'(clip), e.c);
    chk({name, ".clip12"}, int'(clip12), e.c);
`endif
  endtask

  // Inputs are set before calling; DUT and model advance on the same edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (cen) begin
      e = cur_model();
      hist.push_back(e);
      void'(hist.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic set_in(int c0, int c1, int c2, int c3, int g0, int g1, int g2, int g3);
    ch0 = 16'(c0); ch1 = 16'(c1); ch2 = 16'(c2); ch3 = 8'(c3);
    gain0 = 8'(g0); gain1 = 8'(g1); gain2 = 8'(g2); gain3 = 8'(g3);
  endtask

  vec_t vecs[11];
  exp_t e;

  initial begin
    rst = 1'b1; cen = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    // Reset with live non-zero inputs, 3 clk.
    set_in(1234, -777, 5000, 33, 8'h10, 8'h20, 8'h30, 8'h40);
    cen = 1'b1;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cen = i[0];
      tick();
      e.m = 0; e.m12 = 0; e.c = 0;
      chk_outputs("reset_hold", e);
    end
    rst = 1'b0; cen = 1'b0;
    tick(); tick();
    chk_outputs("post_reset_idle", e);
    cen = 1'b1;
    tick();
    chk_outputs("post_reset_cen1", e);
    tick();
    chk_outputs("post_reset_cen2", cur_model());

    vecs[0]  = '{1000, 0, 0, 0, 8'h10, 0, 0, 0, 1000, 62, 0};
    vecs[1]  = '{20000, 0, 0, 0, 8'h40, 0, 0, 0, 32767, 2047, 1};
    vecs[2]  = '{-20000, 0, 0, 0, 8'h40, 0, 0, 0, -32768, -2048, 1};
    vecs[3]  = '{1000, 0, 0, 0, 8'h10, 0, 0, 0, 1000, 62, 0};
    vecs[4]  = '{0, 0, 0, 8'h40, 0, 0, 0, 8'h10, 16384, 1024, 0};
    vecs[5]  = '{0, 0, 0, -64, 0, 0, 0, 8'h10, -16384, -1024, 0};
    vecs[6]  = '{-1, 0, 0, 0, 8'h08, 0, 0, 0, -1, -1, 0};
    vecs[7]  = '{1000, -400, 0, 0, 8'h10, 8'h20, 0, 0, 200, 12, 0};
    vecs[8]  = '{32767, -32767, 0, 0, 8'hFF, 8'hFF, 0, 0, 0, 0, 0};
    vecs[9]  = '{-32768, -32768, -32768, -128, 8'hFF, 8'hFF, 8'hFF, 8'hFF, -32768, -2048, 1};
    vecs[10] = '{32767, 32767, 32767, 127, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 32767, 2047, 1};

    cen = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3,
             vecs[i].g0, vecs[i].g1, vecs[i].g2, vecs[i].g3);
      tick(); tick();
      e.m = vecs[i].m; e.m12 = vecs[i].m12; e.c = vecs[i].c;
      chk_outputs($sformatf("vec%0d", i), e);
    end

    // Unity then cen low: output must hold despite input changes.
    set_in(1000, 0, 0, 0, 8'h10, 0, 0, 0);
    tick(); tick();
    e.m = 1000; e.m12 = 62; e.c = 0;
    chk_outputs("unity", e);
    cen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_in(i * 3000 - 9000, 77, -5, 12, 8'hFF, 8'h80, 8'h11, 8'h22);
      tick();
      chk_outputs("cen_low_hold", e);
    end
    // Two-cycle latency: after one cen the old stage-1 value still emerges.
    cen = 1'b1;
    set_in(-400, 0, 0, 0, 8'h10, 0, 0, 0);
    tick();
    chk_outputs("latency_cen1", e);
    tick();
    e.m = -400; e.m12 = -25; e.c = 0;
    chk_outputs("latency_cen2", e);

    // Random stimulus against the pipeline history model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      cen = $urandom_range(0, 1) == 1;
      ch0 = 16'($urandom); ch1 = 16'($urandom); ch2 = 16'($urandom); ch3 = 8'($urandom);
      gain0 = 8'($urandom); gain1 = 8'($urandom);
      gain2 = 8'($urandom); gain3 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        gain1 = 8'h00; gain2 = 8'h00;
      end
      tick();
      chk_outputs("random", hist[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
